// File: rtl/sys_ibus_master.sv
// -----------------------------------------------------------------------------
// sys_ibus_master
//
// Bus initiator for the systolic-array I/O buffer block. One job, started by a
// `go` pulse, performs:
//   1. write of the max-counter register (0xFFF1),
//   2. write of the run-counter register (0xFFF2),
//   3. 4*ab_len operand writes taken from the input stream (A0, A1, B0, B1),
//   4. write of the start strobe (0xFFF0),
//   5. a programmable wait,
//   6. 4*s_len reads of the result buffers (S0_0, S1_0, S0_1, S1_1), each
//      forwarded on the output stream.
//
// Parameters
//   RD_LAT       cycles between the first `ren` cycle and the rdata sample
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   go                         job start pulse (dropped while busy)
//   cfg_ab_len / cfg_s_len     words per operand / result buffer
//   cfg_max_cntr / cfg_run_cntr  values for the counter registers
//   cfg_wait                   cycles between start write and first read
//   in_valid/in_ready/in_data  operand stream (valid/ready)
//   out_valid/out_ready/out_data/out_last  result stream (valid/ready)
//   wen, ibus_wadr, ibus_wdata write port
//   ren, ibus_radr, ibus_rdata read port
//   busy, done                 job status
//
// Every output is a flop. The combinational processes compute the value each
// output takes in the next cycle, so the state register always names the
// activity currently visible on the outputs.
// -----------------------------------------------------------------------------
module sys_ibus_master #(
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic [9:0]  cfg_ab_len,
  input  logic [8:0]  cfg_s_len,
  input  logic [7:0]  cfg_max_cntr,
  input  logic [7:0]  cfg_run_cntr,
  input  logic [15:0] cfg_wait,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_last,
  output logic        wen,
  output logic [15:0] ibus_wadr,
  output logic [15:0] ibus_wdata,
  output logic        ren,
  output logic [15:0] ibus_radr,
  input  logic [15:0] ibus_rdata,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] ADR_START = 16'hFFF0;
  localparam logic [15:0] ADR_MAX   = 16'hFFF1;
  localparam logic [15:0] ADR_RUN   = 16'hFFF2;
  localparam logic [7:0]  RD_LAT_C  = 8'(RD_LAT);

  // LOAD_END is the cycle that shows the final operand write with in_ready
  // already low; it keeps the start write one cycle behind it.
  typedef enum logic [3:0] {
    S_IDLE,
    S_CFG_MAX,
    S_CFG_RUN,
    S_LOAD,
    S_LOAD_END,
    S_START,
    S_WAIT,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_OUT,
    S_DONE
  } state_t;

  state_t state, next_state;

  // Job configuration latched at go acceptance.
  logic [9:0]  ab_len_q, ab_len_d;
  logic [8:0]  s_len_q, s_len_d;
  logic [7:0]  run_q, run_d;
  logic [15:0] wait_cnt, wait_cnt_d;

  // Operand and result address counters: buffer select plus word index.
  logic [1:0]  ld_buf, ld_buf_d;
  logic [9:0]  ld_idx, ld_idx_d;
  logic [1:0]  rd_buf, rd_buf_d;
  logic [8:0]  rd_idx, rd_idx_d;
  logic [7:0]  lat_cnt, lat_cnt_d;

  // Next-cycle values of the registered outputs.
  logic        wen_d, ren_d, in_ready_d, out_valid_d, out_last_d, busy_d, done_d;
  logic [15:0] ibus_wadr_d, ibus_wdata_d, ibus_radr_d, out_data_d;

  logic accept, ld_last, rd_last, handshake;

  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready;
  assign ld_last   = (ld_buf == 2'd3) && (ld_idx == ab_len_q - 10'd1);
  assign rd_last   = (rd_buf == 2'd3) && (rd_idx == s_len_q - 9'd1);

  // ---------------------------------------------------------------------------
  // State register and all output / datapath flops
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: addresses, data and counters are reset too, because the reset
    // state of the bus outputs is all-zero and must not depend on history.
    if (!rst_n) begin
      state      <= S_IDLE;
      ab_len_q   <= '0;
      s_len_q    <= '0;
      run_q      <= '0;
      wait_cnt   <= '0;
      ld_buf     <= '0;
      ld_idx     <= '0;
      rd_buf     <= '0;
      rd_idx     <= '0;
      lat_cnt    <= '0;
      wen        <= 1'b0;
      ibus_wadr  <= '0;
      ibus_wdata <= '0;
      ren        <= 1'b0;
      ibus_radr  <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= next_state;
      ab_len_q   <= ab_len_d;
      s_len_q    <= s_len_d;
      run_q      <= run_d;
      wait_cnt   <= wait_cnt_d;
      ld_buf     <= ld_buf_d;
      ld_idx     <= ld_idx_d;
      rd_buf     <= rd_buf_d;
      rd_idx     <= rd_idx_d;
      lat_cnt    <= lat_cnt_d;
      wen        <= wen_d;
      ibus_wadr  <= ibus_wadr_d;
      ibus_wdata <= ibus_wdata_d;
      ren        <= ren_d;
      ibus_radr  <= ibus_radr_d;
      in_ready   <= in_ready_d;
      out_valid  <= out_valid_d;
      out_data   <= out_data_d;
      out_last   <= out_last_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:     if (go) next_state = S_CFG_MAX;
      S_CFG_MAX:  next_state = S_CFG_RUN;
      S_CFG_RUN:  next_state = (ab_len_q == '0) ? S_START : S_LOAD;
      S_LOAD:     if (accept && ld_last) next_state = S_LOAD_END;
      S_LOAD_END: next_state = S_START;
      S_START: begin
        if (wait_cnt != '0)      next_state = S_WAIT;
        else if (s_len_q != '0)  next_state = S_RD_ISSUE;
        else                     next_state = S_DONE;
      end
      S_WAIT: begin
        if (wait_cnt == 16'd1)
          next_state = (s_len_q != '0) ? S_RD_ISSUE : S_DONE;
      end
      S_RD_ISSUE: next_state = (RD_LAT_C == '0) ? S_OUT : S_RD_WAIT;
      S_RD_WAIT:  if (lat_cnt == RD_LAT_C) next_state = S_OUT;
      S_OUT:      if (handshake) next_state = rd_last ? S_DONE : S_RD_ISSUE;
      S_DONE:     next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output and datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    ab_len_d     = ab_len_q;
    s_len_d      = s_len_q;
    run_d        = run_q;
    wait_cnt_d   = wait_cnt;
    ld_buf_d     = ld_buf;
    ld_idx_d     = ld_idx;
    rd_buf_d     = rd_buf;
    rd_idx_d     = rd_idx;
    lat_cnt_d    = lat_cnt;
    ibus_wadr_d  = ibus_wadr;
    ibus_wdata_d = ibus_wdata;
    ibus_radr_d  = ibus_radr;
    out_data_d   = out_data;
    wen_d        = 1'b0;

    // Strobes follow directly from where the FSM is heading.
    in_ready_d  = (next_state == S_LOAD);
    ren_d       = (next_state == S_RD_ISSUE) || (next_state == S_RD_WAIT);
    out_valid_d = (next_state == S_OUT);
    done_d      = (next_state == S_DONE);
    busy_d      = (next_state != S_IDLE) && (next_state != S_DONE);

    unique case (state)
      S_IDLE: begin
        if (go) begin
          ab_len_d     = cfg_ab_len;
          s_len_d      = cfg_s_len;
          run_d        = cfg_run_cntr;
          wait_cnt_d   = cfg_wait;
          ld_buf_d     = '0;
          ld_idx_d     = '0;
          rd_buf_d     = '0;
          rd_idx_d     = '0;
          wen_d        = 1'b1;
          ibus_wadr_d  = ADR_MAX;
          ibus_wdata_d = {8'h00, cfg_max_cntr};
        end
      end
      S_CFG_MAX: begin
        wen_d        = 1'b1;
        ibus_wadr_d  = ADR_RUN;
        ibus_wdata_d = {8'h00, run_q};
      end
      S_LOAD: begin
        if (accept) begin
          wen_d        = 1'b1;
          ibus_wadr_d  = {4'h0, ld_buf, ld_idx};
          ibus_wdata_d = in_data;
          if (ld_idx == ab_len_q - 10'd1) begin
            ld_idx_d = '0;
            ld_buf_d = ld_buf + 2'd1;
          end else begin
            ld_idx_d = ld_idx + 10'd1;
          end
        end
      end
      S_WAIT:     wait_cnt_d = wait_cnt - 16'd1;
      S_RD_ISSUE: lat_cnt_d  = 8'd1;
      S_RD_WAIT:  lat_cnt_d  = lat_cnt + 8'd1;
      S_OUT: begin
        if (handshake) begin
          if (rd_idx == s_len_q - 9'd1) begin
            rd_idx_d = '0;
            rd_buf_d = rd_buf + 2'd1;
          end else begin
            rd_idx_d = rd_idx + 9'd1;
          end
        end
      end
      default: ;
    endcase

    // Start strobe, entered from CFG_RUN (empty load) or LOAD_END.
    if (next_state == S_START) begin
      wen_d        = 1'b1;
      ibus_wadr_d  = ADR_START;
      ibus_wdata_d = 16'h0001;
    end

    // Read address uses the counters as they will be after any handshake.
    if (next_state == S_RD_ISSUE)
      ibus_radr_d = {1'b1, 4'h0, rd_buf_d, rd_idx_d};

    // Capture rdata on the last ren cycle; hold the word while in OUT.
    if (next_state == S_OUT && state != S_OUT) begin
      out_data_d = ibus_rdata;
      out_last_d = rd_last;
    end else if (next_state == S_OUT) begin
      out_last_d = out_last;
    end else begin
      out_last_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_sys_ibus_master.sv
// -----------------------------------------------------------------------------
// tb_sys_ibus_master
//
// Self-checking bench for sys_ibus_master. A table of jobs gives each job's
// configuration together with hand-computed totals (done cycle, number of
// writes, read cycles, output words). While each job runs, every write and
// every output word is compared with the address map, and the first read,
// busy and done are compared cycle by cycle. Separate sequences cover the
// reset state and a reset in the middle of LOAD.
// The responder answers a read with radr ^ 0x5A5A only once ren has been
// held for RD_LAT cycles, and returns 0xDEAD before that.
// -----------------------------------------------------------------------------
module tb_sys_ibus_master;

  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        go;
  logic [9:0]  cfg_ab_len;
  logic [8:0]  cfg_s_len;
  logic [7:0]  cfg_max_cntr;
  logic [7:0]  cfg_run_cntr;
  logic [15:0] cfg_wait;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        wen;
  logic [15:0] ibus_wadr;
  logic [15:0] ibus_wdata;
  logic        ren;
  logic [15:0] ibus_radr;
  logic [15:0] ibus_rdata;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  sys_ibus_master #(.RD_LAT(RD_LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .go           (go),
    .cfg_ab_len   (cfg_ab_len),
    .cfg_s_len    (cfg_s_len),
    .cfg_max_cntr (cfg_max_cntr),
    .cfg_run_cntr (cfg_run_cntr),
    .cfg_wait     (cfg_wait),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .wen          (wen),
    .ibus_wadr    (ibus_wadr),
    .ibus_wdata   (ibus_wdata),
    .ren          (ren),
    .ibus_radr    (ibus_radr),
    .ibus_rdata   (ibus_rdata),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Read responder with RD_LAT latency.
  int unsigned rcnt = 0;
  always @(posedge clk) rcnt <= ren ? rcnt + 1 : 0;
  assign ibus_rdata = (ren && rcnt >= RD_LAT) ? (ibus_radr ^ 16'h5A5A) : 16'hDEAD;

  typedef struct {
    int         ab;
    int         sl;
    int         wt;
    logic [7:0] mx;
    logic [7:0] rn;
    int         go2;       // cycle in which a second go is driven (-1: none)
    int         bp;        // 1: hold out_ready low 10 cycles on 2nd result
    int         exp_done;  // cycle of done, counted from the go edge
    int         exp_wen;
    int         exp_ren;
    int         exp_out;
  } job_t;

  job_t jobs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected k-th write of a job and the cycle it must appear in.
  function automatic void exp_write(input int k, input job_t j,
                                    output logic [15:0] a, output logic [15:0] d,
                                    output int cyc);
    int w;
    int m;
    w = 4 * j.ab;
    if (k == 0) begin
      a = 16'hFFF1; d = {8'h00, j.mx}; cyc = 1;
    end else if (k == 1) begin
      a = 16'hFFF2; d = {8'h00, j.rn}; cyc = 2;
    end else if (k < 2 + w) begin
      m   = k - 2;
      a   = 16'((m / j.ab) * 16'h0400 + (m % j.ab));
      d   = 16'(16'h0100 + m);
      cyc = k + 2;
    end else begin
      a = 16'hFFF0; d = 16'h0001; cyc = (w > 0) ? w + 4 : 3;
    end
  endfunction

  task automatic run_job(input job_t j);
    int w, s_cyc, wi, oi, ren_n, done_c, hs_c, bp_left, acc;
    bit bp_done, seen_done;
    logic [15:0] ea, ed, oa;
    int ecyc;
    w = 4 * j.ab;
    s_cyc = (w > 0) ? w + 4 : 3;
    wi = 0; oi = 0; ren_n = 0; done_c = 0; hs_c = 0; bp_left = 0; acc = 0;
    bp_done = 1'b0; seen_done = 1'b0;
    cfg_ab_len   = 10'(j.ab);
    cfg_s_len    = 9'(j.sl);
    cfg_wait     = 16'(j.wt);
    cfg_max_cntr = j.mx;
    cfg_run_cntr = j.rn;
    in_valid  = 1'b1;
    in_data   = 16'h0100;
    out_ready = 1'b1;
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);   // cycle 1 after the go edge
    for (int c = 1; c <= 400; c++) begin
      if (c > 1) @(negedge clk);
      go = (c == j.go2);
      check("wen_ren_excl", wen & ren, 0);
      check("busy", busy, c < j.exp_done);
      check("done", done, c == j.exp_done);
      if (wen) begin
        exp_write(wi, j, ea, ed, ecyc);
        check("wr_adr", ibus_wadr, ea);
        check("wr_data", ibus_wdata, ed);
        check("wr_cycle", c, ecyc);
        wi++;
      end
      if (ren) begin
        if (ren_n == 0) check("first_ren_cycle", c, s_cyc + j.wt + 1);
        ren_n++;
      end
      // Operand stream: the word presented now is taken at the next edge.
      in_data = 16'(16'h0100 + acc);
      if (in_ready) acc++;
      // Result stream.
      if (out_valid) begin
        oa = 16'(16'h8000 + (oi / j.sl) * 16'h0200 + (oi % j.sl));
        check("out_data", out_data, oa ^ 16'h5A5A);
        check("out_last", out_last, oi == 4 * j.sl - 1);
        if (j.bp != 0 && oi == 1 && !bp_done) begin
          bp_left = 10;
          bp_done = 1'b1;
        end
        if (bp_left > 0) begin
          out_ready = 1'b0;
          check("stall_no_ren", ren, 0);
          bp_left--;
        end else begin
          out_ready = 1'b1;
          oi++;
          hs_c = c;
        end
      end else begin
        out_ready = 1'b1;
      end
      if (done) begin
        done_c = c;
        seen_done = 1'b1;
        break;
      end
    end
    go = 1'b0;
    in_valid = 1'b0;
    check("done_seen", seen_done, 1);
    check("done_cycle", done_c, j.exp_done);
    check("wen_count", wi, j.exp_wen);
    check("ren_cycles", ren_n, j.exp_ren);
    check("out_count", oi, j.exp_out);
    if (oi > 0) check("done_after_hs", done_c, hs_c + 1);
    // After done: idle, no pending job.
    repeat (3) begin
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_wen", wen, 0);
      check("idle_done", done, 0);
    end
  endtask

  initial begin
    // ab, sl, wt, mx, rn, go2, bp, done, wen, ren, out
    jobs[0] = '{0, 0, 0, 8'h12, 8'h34,  2, 0,  4,  3,  0, 0};
    jobs[1] = '{2, 1, 5, 8'hAB, 8'hCD, -1, 0, 34, 11, 12, 4};
    jobs[2] = '{1, 1, 0, 8'h01, 8'h02, -1, 0, 25,  7, 12, 4};
    jobs[3] = '{3, 2, 1, 8'hFF, 8'h80, -1, 0, 50, 15, 24, 8};
    jobs[4] = '{0, 1, 3, 8'h55, 8'hAA, -1, 0, 23,  3, 12, 4};
    jobs[5] = '{1, 0, 2, 8'h07, 8'h70, -1, 0, 11,  7,  0, 0};
    jobs[6] = '{1, 1, 0, 8'h3C, 8'hC3, -1, 1, 35,  7, 12, 4};

    rst_n = 1'b0; go = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_ab_len = '0; cfg_s_len = '0; cfg_max_cntr = '0; cfg_run_cntr = '0; cfg_wait = '0;
    repeat (3) @(negedge clk);
    check("rst_wen", wen, 0);
    check("rst_ren", ren, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wadr", ibus_wadr, 0);
    check("rst_wdata", ibus_wdata, 0);
    check("rst_radr", ibus_radr, 0);
    check("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_job(jobs[i]);

    // Reset after three operand words have been accepted.
    cfg_ab_len = 10'd2; cfg_s_len = 9'd1; cfg_wait = 16'd0;
    in_valid = 1'b1; in_data = 16'h0100;
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;   // cycle 1
    repeat (5) @(negedge clk);   // cycle 6: third word being written
    check("midload_wen", wen, 1);
    check("midload_in_ready", in_ready, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("after_rst_wen", wen, 0);
    check("after_rst_in_ready", in_ready, 0);
    check("after_rst_busy", busy, 0);
    check("after_rst_ren", ren, 0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    run_job(jobs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
